// File: rtl/mips_sram_pkg.sv
// Shared constants and FSM state type for the MEM-stage SRAM controller.
package mips_sram_pkg;
   localparam int unsigned SRAM_DW         = 16;
   localparam int unsigned SRAM_AW_DEF     = 18;
   localparam int unsigned DATA_BASE_DEF   = 1024;
   localparam int unsigned WAIT_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_LO = 3'd1,
      WR_HI = 3'd2,
      RD_LO = 3'd3,
      RD_HI = 3'd4,
      DONE  = 3'd5
   } state_e;
endpackage

// File: rtl/sram_addr_map.sv
// Maps a CPU byte address to the low/high SRAM half-word addresses of its 32-bit word.
module sram_addr_map
   import mips_sram_pkg::*;
#(
   parameter int unsigned DATA_BASE = DATA_BASE_DEF,
   parameter int unsigned SRAM_AW   = SRAM_AW_DEF
) (
   input  logic [31:0]        byte_addr,
   output logic [SRAM_AW-1:0] addr_lo,
   output logic [SRAM_AW-1:0] addr_hi
);

   logic [31:0] offset;
   logic        unused_bits;

   // Word index is offset[31:2]; only the bits that fit the SRAM are kept, so larger words alias.
   assign offset      = byte_addr - 32'(DATA_BASE);
   assign addr_lo     = {offset[SRAM_AW:2], 1'b0};
   assign addr_hi     = addr_lo + SRAM_AW'(1);
   assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

endmodule

// File: rtl/sram_controller.sv
// Serves 32-bit loads/stores from a 16-bit SRAM as two timed half-word accesses,
// holding ready low until the pair completes.
module sram_controller
   import mips_sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int unsigned DATA_BASE   = DATA_BASE_DEF,
   parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_result,
   input  logic [31:0]        ST_val,
   output logic [31:0]        MEM_read_value,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRAM_DW-1:0] lo_q, lo_d;
   logic [31:0]        rd_q, rd_d;
   logic [SRAM_AW-1:0] addr_lo, addr_hi;
   logic               dq_oe;
   logic [SRAM_DW-1:0] dq_out;
   logic               last;

   sram_addr_map #(
      .DATA_BASE (DATA_BASE),
      .SRAM_AW   (SRAM_AW)
   ) u_addr_map (
      .byte_addr (ALU_result),
      .addr_lo   (addr_lo),
      .addr_hi   (addr_hi)
   );

   assign last = (cnt_q == CNT_LAST);

   // Next state, wait counter, read capture and SRAM pin control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      lo_d      = lo_q;
      rd_d      = rd_q;
      ready     = 1'b0;
      dq_oe     = 1'b0;
      dq_out    = ST_val[15:0];
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b0;
      SRAM_ADDR = addr_lo;

      case (state_q)
         IDLE: begin
            ready = !(MEM_R_EN || MEM_W_EN);
            if (MEM_W_EN)      state_d = WR_LO;
            else if (MEM_R_EN) state_d = RD_LO;
         end
         WR_LO: begin
            SRAM_WE_N = 1'b0;
            SRAM_OE_N = 1'b1;
            dq_oe     = 1'b1;
            if (last) state_d = WR_HI;
         end
         WR_HI: begin
            SRAM_WE_N = 1'b0;
            SRAM_OE_N = 1'b1;
            SRAM_ADDR = addr_hi;
            dq_oe     = 1'b1;
            dq_out    = ST_val[31:16];
            if (last) state_d = DONE;
         end
         RD_LO: begin
            if (last) begin
               lo_d    = SRAM_DQ;
               state_d = RD_HI;
            end
         end
         RD_HI: begin
            SRAM_ADDR = addr_hi;
            if (last) begin
               rd_d    = {SRAM_DQ, lo_q};
               state_d = DONE;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Counter runs only inside an access state and restarts for the next one.
      if ((state_q == WR_LO) || (state_q == WR_HI) || (state_q == RD_LO) || (state_q == RD_HI)) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lo_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         rd_q    <= rd_d;
      end
   end

   assign MEM_read_value = rd_q;
   assign SRAM_DQ        = dq_oe ? dq_out : {SRAM_DW{1'bz}};
   assign SRAM_CE_N      = 1'b0;
   assign SRAM_UB_N      = 1'b0;
   assign SRAM_LB_N      = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed table, corner sequences and random traffic against a word-level model.
module tb_sram_controller;
   import mips_sram_pkg::*;

   localparam int unsigned W    = 2;
   localparam int unsigned AW   = 18;
   localparam int unsigned BASE = 1024;

   logic        clk = 1'b0;
   logic        rst, r_en, w_en;
   logic [31:0] alu, st, rdv;
   logic        ready;
   wire  [15:0] dq;
   logic [17:0] addr;
   logic        we_n, oe_n, ce_n, ub_n, lb_n;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W), .DATA_BASE(BASE), .SRAM_AW(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .MEM_R_EN       (r_en),
      .MEM_W_EN       (w_en),
      .ALU_result     (alu),
      .ST_val         (st),
      .MEM_read_value (rdv),
      .ready          (ready),
      .SRAM_DQ        (dq),
      .SRAM_ADDR      (addr),
      .SRAM_WE_N      (we_n),
      .SRAM_OE_N      (oe_n),
      .SRAM_CE_N      (ce_n),
      .SRAM_UB_N      (ub_n),
      .SRAM_LB_N      (lb_n)
   );

   // Behavioural asynchronous SRAM; pull-ups make an undriven bus read as all ones.
   logic [15:0] mem [0:(1<<AW)-1];
   logic        dev_en;
   assign dq = (dev_en && !oe_n && we_n) ? mem[addr] : 16'hzzzz;
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (dq[i]);
   end
   always @(posedge clk) if (!we_n) mem[addr] <= dq;

   // Word-level reference: 32-bit words indexed modulo the SRAM word count.
   logic [31:0] ref_mem [int];
   logic [31:0] ref_rd;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic int word_of(input logic [31:0] a);
      return int'(((a - 32'(BASE)) >> 2) % 32'h20000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request from a negedge in IDLE through DONE; returns at the negedge of the following cycle.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit hold);
      int          wd, lat;
      logic [17:0] lo;
      wd   = word_of(a);
      lo   = 18'(wd * 2);
      r_en = r; w_en = w; alu = a; st = d;
      #1 chk("ready_req", 32'(ready), 32'(0));
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); @(negedge clk);
         lat = c;
         if (ready) break;
         chk("sram_addr", 32'(addr), (c <= int'(W)) ? 32'(lo) : 32'(lo) + 32'd1);
         chk("we_n", 32'(we_n), w ? 32'(0) : 32'(1));
         chk("oe_n", 32'(oe_n), w ? 32'(1) : 32'(0));
      end
      chk("latency", 32'(lat), 32'(1 + 2 * W));
      if (w) ref_mem[wd] = d;
      else   ref_rd = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
      chk("read_value", rdv, ref_rd);
      if (!hold) begin r_en = 1'b0; w_en = 1'b0; end
      @(posedge clk); @(negedge clk);
      if (!hold) chk("ready_idle", 32'(ready), 32'(1));
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] a, d;
      logic [17:0] exp_lo;
      logic [31:0] exp_rv;
   } vec_t;

   vec_t tbl [8];

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
      rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = 32'd1024; st = 32'h0; dev_en = 1'b1;
      ref_rd = 32'h0;

      tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0,       32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'hDEADBEEF};
      tbl[2] = '{1'b0, 1'b1, 32'd1047, 32'hA5A50F0F, 18'd10,      32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b0, 32'd1047, 32'h0,        18'd10,      32'hA5A50F0F};
      tbl[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   32'hA5A50F0F};
      tbl[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,   32'hCAFEF00D};
      tbl[6] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2,       32'hCAFEF00D};
      tbl[7] = '{1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,       32'h12345678};

      repeat (2) @(negedge clk);
      chk("rst_read_value", rdv, 32'h0);
      chk("rst_we_n", 32'(we_n), 32'(1));
      chk("rst_ready", 32'(ready), 32'(1));
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0);
         chk("tbl_read_value", rdv, tbl[i].exp_rv);
         chk("tbl_idle_addr", 32'(addr), 32'(tbl[i].exp_lo));
         if (tbl[i].w) begin
            chk("tbl_mem_lo", 32'(mem[tbl[i].exp_lo]), 32'(tbl[i].d[15:0]));
            chk("tbl_mem_hi", 32'(mem[tbl[i].exp_lo + 18'd1]), 32'(tbl[i].d[31:16]));
         end
      end

      // Held request completes once and is not restarted
      access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
      chk("held_ready_pending", 32'(ready), 32'(0));
      r_en = 1'b0;
      #1 chk("held_no_restart", 32'(ready), 32'(1));
      @(posedge clk); @(negedge clk);
      chk("held_idle", 32'(ready), 32'(1));

      // Reset while in RD_HI
      r_en = 1'b1; alu = 32'd1047;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      dev_en = 1'b0;
      #1;
      chk("rst_mid_read_value", rdv, 32'h0);
      chk("rst_mid_we_n", 32'(we_n), 32'(1));
      chk("rst_mid_dq_free", 32'(dq), 32'hFFFF);
      chk("rst_mid_ready_req", 32'(ready), 32'(0));
      r_en = 1'b0;
      #1 chk("rst_mid_ready_idle", 32'(ready), 32'(1));
      @(negedge clk);
      rst = 1'b0; dev_en = 1'b1; ref_rd = 32'h0;

      // Idle bus
      dev_en = 1'b0; st = 32'h0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'(1));
         chk("idle_we_n", 32'(we_n), 32'(1));
         chk("idle_dq_free", 32'(dq), 32'hFFFF);
      end
      dev_en = 1'b1;

      // Random traffic including aliased word indices
      for (int i = 0; i < 40; i++) begin
         int unsigned op, wsel;
         op   = $urandom_range(0, 2);
         wsel = $urandom_range(0, 15) + (($urandom_range(0, 1) == 1) ? 32'h20000 : 32'h0);
         access(op != 1, op != 0, 32'(BASE) + 32'(4 * wsel) + 32'($urandom_range(0, 3)),
                $urandom, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
